bep_frame_decoder: RTL
======================

Name: bep_frame_decoder

Overview:
Parametrised successor to the fixed-layout thermostat serial decoder. It hunts a bit stream for a configurable sync preamble, then captures a configurable-length payload MSB-first. It verifies a trailing additive checksum byte and presents the whole payload as one registered word with a single-cycle valid strobe. It sits between the input conditioning state machine, which supplies bit_in/bit_valid, and the field-split and display logic.

Parameters:
PREAMBLE_BITS, 32, sync word length in bits; legal range 8..64.
PREAMBLE_PATTERN, 32'hA5A5_F00F, sync word, compared MSB-first.
PAYLOAD_BITS, 160, bits captured after the sync word, including the checksum byte; must be a multiple of 8 and at least 16.
TIMEOUT_CYCLES, 65535, idle clocks without bit_valid in RECEIVE before the frame is aborted; legal range 1..2^20-1.

Ports:
clock  input  1  system clock; all logic is on the rising edge
reset  input  1  synchronous, active-high reset
bit_in  input  1  serial data bit; sampled only when bit_valid=1
bit_valid  input  1  one-cycle strobe per received bit
frame_data  output  PAYLOAD_BITS  last completed payload; the first received bit is at the MSB
frame_valid  output  1  one-cycle pulse when frame_data updates
checksum_ok  output  1  checksum result for the current frame_data; held until the next frame
busy  output  1  high while in RECEIVE
frame_count  output  8  completed frames, good or bad; saturates at 255
error_count  output  8  checksum failures plus timeouts; saturates at 255

Behaviour:
- Reset: state=HUNT; the sync shift register, payload shift register, bit counter, gap counter, frame_data, frame_valid, checksum_ok, busy, frame_count and error_count are all 0. Reset overrides every other event in the same cycle, including mid-frame.
- HUNT:
  - On each bit_valid, shift bit_in into the PREAMBLE_BITS-wide sync register at the LSB end.
  - If the post-shift value equals PREAMBLE_PATTERN, go to RECEIVE on the next edge with bit counter=0, gap counter=0 and checksum accumulator=0.
  - Overlapping preambles are matched: a sliding window, with no bit skipping.
- RECEIVE:
  - On each bit_valid, shift bit_in into the payload register at the LSB end, increment the bit counter and clear the gap counter.
  - Each completed byte, except the final byte, is added mod 256 to the checksum accumulator.
  - busy=1 throughout.
- Completion: the bit_valid that delivers bit PAYLOAD_BITS-1 ends the frame. On the next edge:
  - frame_data takes the full payload.
  - frame_valid=1 for exactly one cycle.
  - checksum_ok = (accumulator == final byte).
  - frame_count increments (saturating). error_count increments (saturating) if checksum_ok=0.
  - State returns to HUNT with the sync register cleared to 0, so a fresh full preamble is required.
  - Latency: frame_valid is high in the cycle after the last bit's bit_valid cycle.
- Timeout:
  - In RECEIVE, every cycle without bit_valid increments the gap counter.
  - When the counter reaches TIMEOUT_CYCLES, go to HUNT and clear the sync register. error_count increments (saturating).
  - frame_data, checksum_ok and frame_count are unchanged, and frame_valid is not asserted.
- Timeout expiry and bit_valid in the same cycle: bit_valid wins, and the gap counter clears.
- bit_valid is ignored in the completion cycle. The state is already HUNT, but the sync register is cleared on the same edge, so that bit is dropped.
- Both counters hold at 255 and never wrap.
- frame_data and checksum_ok change only on a completion edge. Between frames they hold the previous values, including while a new frame is being received.
- The checksum covers payload bytes 0..N-2, each taken as MSB-first groups of 8 received bits. Byte N-1 is the checksum.

Test Plan:
- Good frame: reset; send 0xA5A5F00F, then 19 bytes 0x01..0x13 and checksum byte 0xBE (sum 190), one bit every 4 clocks. Expect one frame_valid pulse 1 cycle after the last bit_valid, frame_data[159:152]=0x01, frame_data[7:0]=0xBE, checksum_ok=1, frame_count=1, error_count=0, busy falling in the same cycle.
- Bad checksum: same frame with last byte 0xBF. Expect frame_valid=1, checksum_ok=0, frame_count=1, error_count=1, with frame_data updated.
- Sliding sync: prefix the preamble with noise bits 1,0,1 and a partial 0xA5A5. Expect lock only after the full 32-bit match and correct payload alignment, with frame_data identical to the good-frame case.
- Timeout: send the preamble plus 40 payload bits, then stall with TIMEOUT_CYCLES=16 in the bench. Expect busy to drop exactly 16 cycles after the last bit_valid, error_count=1, no frame_valid, and frame_data/frame_count unchanged. A following good frame decodes normally.
- Reset mid-frame: assert reset after 80 payload bits. Expect all outputs 0 on the next edge; the remaining bits produce no frame_valid; a subsequent full frame is accepted.
- Saturation: drive 260 bad-checksum frames. Expect frame_count and error_count both held at 255, with frame_valid still pulsing once per frame.

Source files
------------

// File: rtl/bep_frame_decoder_if.sv
// bep_frame_decoder_if: serial bit stream in, decoded frame and status out.
interface bep_frame_decoder_if #(
    parameter int PAYLOAD_BITS = 160
);
    logic                    bit_in;
    logic                    bit_valid;
    logic [PAYLOAD_BITS-1:0] frame_data;
    logic                    frame_valid;
    logic                    checksum_ok;
    logic                    busy;
    logic [7:0]              frame_count;
    logic [7:0]              error_count;
    modport master (
        output bit_in, bit_valid,
        input  frame_data, frame_valid, checksum_ok, busy, frame_count, error_count
    );
    modport slave (
        input  bit_in, bit_valid,
        output frame_data, frame_valid, checksum_ok, busy, frame_count, error_count
    );
endinterface

// File: rtl/bep_frame_decoder.sv
// bep_frame_decoder: hunts a sliding sync preamble, then captures an MSB-first payload
// whose final byte is the mod-256 sum of all earlier payload bytes.
module bep_frame_decoder #(
    parameter int          PREAMBLE_BITS    = 32,
    parameter logic [63:0] PREAMBLE_PATTERN = 64'h0000_0000_A5A5_F00F,
    parameter int          PAYLOAD_BITS     = 160,
    parameter int          TIMEOUT_CYCLES   = 65535
) (
    input logic               clock,
    input logic               reset,
    bep_frame_decoder_if.slave bus
);
    localparam logic [0:0] HUNT    = 1'b0;
    localparam logic [0:0] RECEIVE = 1'b1;
    localparam int CW = $clog2(PAYLOAD_BITS);
    localparam logic [PREAMBLE_BITS-1:0] SYNC = PREAMBLE_PATTERN[PREAMBLE_BITS-1:0];
    localparam logic [CW-1:0] LAST = CW'(PAYLOAD_BITS - 1);
    localparam logic [19:0] TMO = 20'(TIMEOUT_CYCLES);

    logic [0:0]               state_q, state_d;
    logic [PREAMBLE_BITS-1:0] sync_q, sync_d, sync_shift;
    logic [PAYLOAD_BITS-1:0]  pay_q, pay_d, frame_data_q, frame_data_d;
    logic [CW-1:0]            cnt_q, cnt_d;
    logic [19:0]              gap_q, gap_d, gap_inc;
    logic [7:0]               acc_q, acc_d, byte_in;
    logic                     frame_valid_q, frame_valid_d, checksum_ok_q, checksum_ok_d;
    logic [7:0]               frame_count_q, frame_count_d, error_count_q, error_count_d;
    logic [7:0]               fc_sat, ec_sat;

    always_comb begin
        sync_shift    = {sync_q[PREAMBLE_BITS-2:0], bus.bit_in};
        byte_in       = {pay_q[6:0], bus.bit_in};
        gap_inc       = gap_q + 20'd1;
        fc_sat        = frame_count_q + {7'd0, frame_count_q != 8'hFF};
        ec_sat        = error_count_q + {7'd0, error_count_q != 8'hFF};
        state_d       = state_q;
        sync_d        = sync_q;
        pay_d         = pay_q;
        cnt_d         = cnt_q;
        gap_d         = gap_q;
        acc_d         = acc_q;
        frame_data_d  = frame_data_q;
        frame_valid_d = 1'b0;
        checksum_ok_d = checksum_ok_q;
        frame_count_d = frame_count_q;
        error_count_d = error_count_q;
        if (state_q == HUNT) begin
            // A bit arriving in the completion cycle is dropped so a fresh full preamble is needed.
            if (bus.bit_valid && !frame_valid_q) begin
                sync_d = sync_shift;
                if (sync_shift == SYNC) begin
                    state_d = RECEIVE;
                    cnt_d   = '0;
                    gap_d   = '0;
                    acc_d   = '0;
                end
            end
        end else if (bus.bit_valid) begin
            pay_d = {pay_q[PAYLOAD_BITS-2:0], bus.bit_in};
            cnt_d = cnt_q + CW'(1);
            gap_d = '0;
            if (cnt_q == LAST) begin
                state_d       = HUNT;
                sync_d        = '0;
                frame_data_d  = pay_d;
                frame_valid_d = 1'b1;
                checksum_ok_d = acc_q == byte_in;
                frame_count_d = fc_sat;
                error_count_d = (acc_q == byte_in) ? error_count_q : ec_sat;
            end else if (cnt_q[2:0] == 3'd7) begin
                acc_d = acc_q + byte_in;
            end
        end else begin
            gap_d = gap_inc;
            if (gap_inc == TMO) begin
                state_d       = HUNT;
                sync_d        = '0;
                error_count_d = ec_sat;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= HUNT;
            sync_q        <= '0;
            pay_q         <= '0;
            cnt_q         <= '0;
            gap_q         <= '0;
            acc_q         <= '0;
            frame_data_q  <= '0;
            frame_valid_q <= 1'b0;
            checksum_ok_q <= 1'b0;
            frame_count_q <= '0;
            error_count_q <= '0;
        end else begin
            state_q       <= state_d;
            sync_q        <= sync_d;
            pay_q         <= pay_d;
            cnt_q         <= cnt_d;
            gap_q         <= gap_d;
            acc_q         <= acc_d;
            frame_data_q  <= frame_data_d;
            frame_valid_q <= frame_valid_d;
            checksum_ok_q <= checksum_ok_d;
            frame_count_q <= frame_count_d;
            error_count_q <= error_count_d;
        end
    end

    assign bus.frame_data  = frame_data_q;
    assign bus.frame_valid = frame_valid_q;
    assign bus.checksum_ok = checksum_ok_q;
    assign bus.busy        = state_q == RECEIVE;
    assign bus.frame_count = frame_count_q;
    assign bus.error_count = error_count_q;
endmodule
